spi_cmd_queue: RTL and testbench
================================

# spi_cmd_queue

Command queue and transaction sequencer sitting directly upstream of `spi_master`. It buffers SPI commands (payload, chip address, length) from a ready/valid producer, issues them one at a time through the master's `start_trans`/`busy` handshake, and captures each completed `rx_data` word with its chip address into a result FIFO. The CPU or bus side needs no knowledge of SPI timing, and back-to-back transfers get a guaranteed chip-select idle gap.

## Interface
Parameters:
- `SLAVE_COUNT`, 8, number of chip selects; address width `AW = $clog2(SLAVE_COUNT)`.
- `DEPTH`, 4, entries in each of the command and result FIFOs; power of two, ≥2.
- `GAP_CYCLES`, 2, `clk` cycles idle between a capture and the next launch; 0 is legal.

Ports:
- `clk`  in  1  system clock, same clock as `spi_master`.
- `rst`  in  1  reset, asynchronous, active-low.
- `cmd_valid`  in  1  command offered.
- `cmd_ready`  out  1  command FIFO not full.
- `cmd_data`  in  32  transmit payload, MSB-aligned to length as `spi_master` expects.
- `cmd_addr`  in  AW  target chip index.
- `cmd_len`  in  2  00 = 8 bit, 01 = 16 bit, 10 = 24 bit, 11 = 32 bit.
- `rsp_valid`  out  1  result FIFO not empty.
- `rsp_ready`  in  1  consumer takes the head result.
- `rsp_data`  out  32  received word (head entry).
- `rsp_addr`  out  AW  chip index of that result.
- `start_trans`  out  1  to master.
- `busy`  in  1  from master.
- `tx_data`  out  32  to master.
- `chipADDRS`  out  AW  to master.
- `transaction_length`  out  2  to master.
- `rx_data`  in  32  from master.
- `cmd_count`, `rsp_count`  out  $clog2(DEPTH)+1  FIFO occupancy.

## Operation
- Command FIFO:
  - Push on `cmd_valid & cmd_ready`.
  - `cmd_ready = (cmd_count != DEPTH)`.
  - Pointers wrap modulo DEPTH.
  - The count has one extra bit so full and empty are distinguishable.
- Result FIFO:
  - Pop on `rsp_valid & rsp_ready`.
  - `rsp_data`/`rsp_addr` show the head entry combinationally from storage.
  - Contents are undefined while `rsp_valid` = 0.
- Holding registers `tx_data`, `chipADDRS`, `transaction_length`:
  - Loaded from the command FIFO head on the IDLE→LAUNCH edge. That same edge pops the entry.
  - Held stable until the next launch.
- Sequencer states:
  - IDLE: go to LAUNCH when `cmd_count != 0` and `rsp_count != DEPTH`. Otherwise stay.
  - LAUNCH: `start_trans` = 1 for exactly this one cycle. Always go to WAIT_BUSY.
  - WAIT_BUSY: go to WAIT_DONE when `busy` = 1.
  - WAIT_DONE: go to CAPTURE when `busy` = 0.
  - CAPTURE: push `{rx_data, chipADDRS}` into the result FIFO. Go to GAP if GAP_CYCLES > 0, else IDLE.
  - GAP: down-counter loaded with GAP_CYCLES-1 on entry. Go to IDLE when it reaches 0.
- `start_trans` is a registered decode of LAUNCH and is glitch-free.
- At most one transaction is in flight. Because the launch condition requires a free result slot, the CAPTURE push can never overflow.
- Simultaneous events:
  - Command push and pop in the same cycle: `cmd_count` unchanged, both take effect. `cmd_ready` reflects the count before the edge, so no push occurs while full even if a pop happens that cycle.
  - Result push (CAPTURE) and pop in the same cycle: `rsp_count` unchanged.
- Reset, asserted at any time including mid-transaction:
  - FSM → IDLE. Both FIFOs empty, counts 0, `start_trans` = 0.
  - `tx_data`, `chipADDRS`, `transaction_length` = 0.
  - `cmd_ready` = 1, `rsp_valid` = 0.
  - Any in-flight result is discarded. The master is reset by the same system reset.

## Timing
- Command pushed at edge E with the queue idle: LAUNCH registered at E+1, `start_trans` high from E+1 to E+2.
- Master enters pre-transfer at E+2. `busy` is seen high at E+3, and the FSM enters WAIT_DONE.
- The master's `rx_data` updates on the same edge where `busy` falls. CAPTURE therefore samples a valid word one cycle after that edge, and `rsp_valid` rises one cycle after CAPTURE.
- Minimum idle time between `busy` falling and the next `start_trans`:
  - 1 (CAPTURE) + GAP_CYCLES + 1 (IDLE) cycles.
  - This keeps all chip selects high for at least GAP_CYCLES+2 cycles.
- Producer-side throughput: one command accepted per cycle until full.

## Test plan
- Single 8-bit command: `cmd_data`=0x000000A5, addr 3, len 00, with a master model looping MOSI→MISO.
  - `start_trans` pulses for exactly one cycle.
  - `rsp_data`=0x000000A5 and `rsp_addr`=3.
  - `rsp_valid` rises 1 cycle after CAPTURE.
- Fill the command FIFO with 4 commands of mixed lengths (00, 01, 10, 11) while `busy` is held high.
  - `cmd_ready` falls after the 4th push.
  - All 4 results return in order with the correct addresses.
- `rsp_ready` held 0 with 6 commands queued.
  - Exactly 4 transactions run, then the FSM stalls in IDLE with `rsp_count`=4.
  - One pop lets exactly one more launch.
- GAP_CYCLES=0 and GAP_CYCLES=3: measure from `busy` falling to the next `start_trans`.
  - Required 2 and 5 cycles respectively.
- Simultaneous push and pop on a full command FIFO, and a CAPTURE coinciding with a result pop.
  - Counts unchanged, no data lost or duplicated.
- Assert `rst` low while in WAIT_DONE with 2 commands queued.
  - Outputs go to their reset values immediately.
  - After release, `cmd_count`=0, `rsp_valid`=0, and no `start_trans` is issued.

Source files
------------

// File: rtl/spi_cmd_queue.sv
// -----------------------------------------------------------------------------
// spi_cmd_queue
// Command queue and transaction sequencer placed in front of spi_master.
// Commands (payload, chip address, length) are buffered in a small FIFO,
// issued one at a time over the master's start_trans/busy handshake, and each
// completed rx_data word is stored together with its chip address in a result
// FIFO. Back-to-back transfers are separated by a guaranteed idle gap.
//
// Ports
//   clk, rst                    system clock, asynchronous active-low reset
//   cmd_valid/ready/data/addr/len   producer side, ready/valid
//   rsp_valid/ready/data/addr       consumer side, ready/valid
//   start_trans, busy, tx_data, chipADDRS, transaction_length, rx_data
//                               handshake and data towards spi_master
//   cmd_count, rsp_count        FIFO occupancy (one extra bit: full != empty)
// -----------------------------------------------------------------------------
module spi_cmd_queue #(
    parameter  int SLAVE_COUNT = 8,
    parameter  int DEPTH       = 4,
    parameter  int GAP_CYCLES  = 2,
    localparam int AW          = (SLAVE_COUNT > 1) ? $clog2(SLAVE_COUNT) : 1,
    localparam int CW          = $clog2(DEPTH) + 1
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          cmd_valid,
    output logic          cmd_ready,
    input  logic [31:0]   cmd_data,
    input  logic [AW-1:0] cmd_addr,
    input  logic [1:0]    cmd_len,
    output logic          rsp_valid,
    input  logic          rsp_ready,
    output logic [31:0]   rsp_data,
    output logic [AW-1:0] rsp_addr,
    output logic          start_trans,
    input  logic          busy,
    output logic [31:0]   tx_data,
    output logic [AW-1:0] chipADDRS,
    output logic [1:0]    transaction_length,
    input  logic [31:0]   rx_data,
    output logic [CW-1:0] cmd_count,
    output logic [CW-1:0] rsp_count
);
    localparam int PW       = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int GW       = (GAP_CYCLES > 1) ? $clog2(GAP_CYCLES) : 1;
    localparam int GAP_LOAD = (GAP_CYCLES > 0) ? GAP_CYCLES - 1 : 0;

    localparam logic [CW-1:0] CNT_ZERO = {CW{1'b0}};
    localparam logic [CW-1:0] CNT_ONE  = CW'(1'b1);
    localparam logic [CW-1:0] CNT_FULL = CW'(DEPTH);
    localparam logic [PW-1:0] PTR_ZERO = {PW{1'b0}};
    localparam logic [PW-1:0] PTR_ONE  = PW'(1'b1);
    localparam logic [GW-1:0] GAP_ZERO = {GW{1'b0}};
    localparam logic [GW-1:0] GAP_ONE  = GW'(1'b1);

    typedef enum logic [2:0] {
        S_IDLE      = 3'd0,
        S_LAUNCH    = 3'd1,
        S_WAIT_BUSY = 3'd2,
        S_WAIT_DONE = 3'd3,
        S_CAPTURE   = 3'd4,
        S_GAP       = 3'd5
    } state_t;

    state_t        r_state;
    state_t        w_state_nxt;

    logic [31:0]   r_cmd_data [DEPTH];
    logic [AW-1:0] r_cmd_addr [DEPTH];
    logic [1:0]    r_cmd_len  [DEPTH];
    logic [PW-1:0] r_cmd_wr;
    logic [PW-1:0] r_cmd_rd;
    logic [CW-1:0] r_cmd_count;

    logic [31:0]   r_rsp_data [DEPTH];
    logic [AW-1:0] r_rsp_addr [DEPTH];
    logic [PW-1:0] r_rsp_wr;
    logic [PW-1:0] r_rsp_rd;
    logic [CW-1:0] r_rsp_count;

    logic [31:0]   r_tx_data;
    logic [AW-1:0] r_chip_addr;
    logic [1:0]    r_len;
    logic          r_start;
    logic [GW-1:0] r_gap_cnt;

    logic          w_cmd_push;
    logic          w_cmd_pop;
    logic          w_rsp_push;
    logic          w_rsp_pop;
    logic          w_gap_load;

    // cmd_ready looks only at the registered count, so a full FIFO never
    // accepts a push even when the sequencer pops in the same cycle.
    assign cmd_ready          = (r_cmd_count != CNT_FULL);
    assign rsp_valid          = (r_rsp_count != CNT_ZERO);
    assign w_cmd_push         = cmd_valid & cmd_ready;
    assign w_rsp_pop          = rsp_valid & rsp_ready;
    assign cmd_count          = r_cmd_count;
    assign rsp_count          = r_rsp_count;
    assign rsp_data           = r_rsp_data[r_rsp_rd];
    assign rsp_addr           = r_rsp_addr[r_rsp_rd];
    assign start_trans        = r_start;
    assign tx_data            = r_tx_data;
    assign chipADDRS          = r_chip_addr;
    assign transaction_length = r_len;

    // Command FIFO storage; contents are qualified by the count, so no reset
    always_ff @(posedge clk) begin
        if (w_cmd_push) begin
            r_cmd_data[r_cmd_wr] <= cmd_data;
            r_cmd_addr[r_cmd_wr] <= cmd_addr;
            r_cmd_len[r_cmd_wr]  <= cmd_len;
        end
    end

    // Command FIFO pointers and occupancy
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_cmd_wr    <= PTR_ZERO;
            r_cmd_rd    <= PTR_ZERO;
            r_cmd_count <= CNT_ZERO;
        end else begin
            if (w_cmd_push) r_cmd_wr <= r_cmd_wr + PTR_ONE;
            if (w_cmd_pop)  r_cmd_rd <= r_cmd_rd + PTR_ONE;
            case ({w_cmd_push, w_cmd_pop})
                2'b10:   r_cmd_count <= r_cmd_count + CNT_ONE;
                2'b01:   r_cmd_count <= r_cmd_count - CNT_ONE;
                default: r_cmd_count <= r_cmd_count;
            endcase
        end
    end

    // Result FIFO storage; head is shown combinationally on rsp_data/rsp_addr
    always_ff @(posedge clk) begin
        if (w_rsp_push) begin
            r_rsp_data[r_rsp_wr] <= rx_data;
            r_rsp_addr[r_rsp_wr] <= r_chip_addr;
        end
    end

    // Result FIFO pointers and occupancy
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_rsp_wr    <= PTR_ZERO;
            r_rsp_rd    <= PTR_ZERO;
            r_rsp_count <= CNT_ZERO;
        end else begin
            if (w_rsp_push) r_rsp_wr <= r_rsp_wr + PTR_ONE;
            if (w_rsp_pop)  r_rsp_rd <= r_rsp_rd + PTR_ONE;
            case ({w_rsp_push, w_rsp_pop})
                2'b10:   r_rsp_count <= r_rsp_count + CNT_ONE;
                2'b01:   r_rsp_count <= r_rsp_count - CNT_ONE;
                default: r_rsp_count <= r_rsp_count;
            endcase
        end
    end

    // Sequencer next-state decode and FIFO push/pop strobes
    always_comb begin
        w_state_nxt = r_state;
        w_cmd_pop   = 1'b0;
        w_rsp_push  = 1'b0;
        w_gap_load  = 1'b0;
        case (r_state)
            S_IDLE: begin
                // A free result slot is required before launching, so the
                // capture push can never overflow the result FIFO.
                if ((r_cmd_count != CNT_ZERO) && (r_rsp_count != CNT_FULL)) begin
                    w_state_nxt = S_LAUNCH;
                    w_cmd_pop   = 1'b1;
                end else begin
                    w_state_nxt = S_IDLE;
                end
            end
            S_LAUNCH: begin
                w_state_nxt = S_WAIT_BUSY;
            end
            S_WAIT_BUSY: begin
                if (busy) w_state_nxt = S_WAIT_DONE;
                else      w_state_nxt = S_WAIT_BUSY;
            end
            S_WAIT_DONE: begin
                if (!busy) w_state_nxt = S_CAPTURE;
                else       w_state_nxt = S_WAIT_DONE;
            end
            S_CAPTURE: begin
                w_rsp_push = 1'b1;
                if (GAP_CYCLES > 0) begin
                    w_state_nxt = S_GAP;
                    w_gap_load  = 1'b1;
                end else begin
                    w_state_nxt = S_IDLE;
                end
            end
            S_GAP: begin
                if (r_gap_cnt == GAP_ZERO) w_state_nxt = S_IDLE;
                else                       w_state_nxt = S_GAP;
            end
            default: begin
                w_state_nxt = S_IDLE;
            end
        endcase
    end

    // Sequencer state and registered start_trans decode (high only in LAUNCH)
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state <= S_IDLE;
            r_start <= 1'b0;
        end else begin
            r_state <= w_state_nxt;
            r_start <= (w_state_nxt == S_LAUNCH);
        end
    end

    // Inter-transfer gap down-counter
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_gap_cnt <= GAP_ZERO;
        end else if (w_gap_load) begin
            r_gap_cnt <= GW'(GAP_LOAD);
        end else if ((r_state == S_GAP) && (r_gap_cnt != GAP_ZERO)) begin
            r_gap_cnt <= r_gap_cnt - GAP_ONE;
        end else begin
            r_gap_cnt <= r_gap_cnt;
        end
    end

    // Holding registers towards the master, loaded as the head is popped
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_tx_data   <= 32'h0000_0000;
            r_chip_addr <= {AW{1'b0}};
            r_len       <= 2'b00;
        end else if (w_cmd_pop) begin
            r_tx_data   <= r_cmd_data[r_cmd_rd];
            r_chip_addr <= r_cmd_addr[r_cmd_rd];
            r_len       <= r_cmd_len[r_cmd_rd];
        end else begin
            r_tx_data   <= r_tx_data;
            r_chip_addr <= r_chip_addr;
            r_len       <= r_len;
        end
    end

endmodule

// File: tb/tb_spi_cmd_queue.sv
// -----------------------------------------------------------------------------
// tb_spi_cmd_queue
// Directed bench for spi_cmd_queue. The main instance (GAP_CYCLES=2) talks to
// a loopback master model whose busy phase can be stretched with m_hold; two
// further instances (GAP_CYCLES=0 and 3) measure the inter-transfer idle gap.
// -----------------------------------------------------------------------------
module tb_spi_cmd_queue;
    localparam int AW = 3;
    localparam int CW = 3;

    logic          clk = 1'b0;
    logic          rst;
    logic          cmd_valid;
    logic          cmd_ready;
    logic [31:0]   cmd_data;
    logic [AW-1:0] cmd_addr;
    logic [1:0]    cmd_len;
    logic          rsp_valid;
    logic          rsp_ready;
    logic [31:0]   rsp_data;
    logic [AW-1:0] rsp_addr;
    logic          start_trans;
    logic          busy;
    logic [31:0]   tx_data;
    logic [AW-1:0] chipADDRS;
    logic [1:0]    transaction_length;
    logic [31:0]   rx_data;
    logic [CW-1:0] cmd_count;
    logic [CW-1:0] rsp_count;

    logic          m_hold;
    logic [2:0]    m_cnt;
    logic [1:0]    g_cmd_valid;
    logic [1:0]    g_busy;
    logic [1:0]    g_start;

    int n_checks = 0;
    int n_errors = 0;

    always #5 clk = ~clk;

    spi_cmd_queue #(.SLAVE_COUNT(8), .DEPTH(4), .GAP_CYCLES(2)) u_dut (
        .clk(clk), .rst(rst),
        .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_data(cmd_data),
        .cmd_addr(cmd_addr), .cmd_len(cmd_len),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_data(rsp_data),
        .rsp_addr(rsp_addr),
        .start_trans(start_trans), .busy(busy), .tx_data(tx_data),
        .chipADDRS(chipADDRS), .transaction_length(transaction_length),
        .rx_data(rx_data), .cmd_count(cmd_count), .rsp_count(rsp_count)
    );

    // Loopback master: busy one cycle after start_trans, rx_data = tx_data
    // updated on the edge where busy falls; m_hold stretches the busy phase.
    always @(posedge clk or negedge rst) begin
        if (!rst) begin
            busy <= 1'b0; m_cnt <= 3'd0; rx_data <= 32'h0;
        end else if (!busy) begin
            if (start_trans) begin busy <= 1'b1; m_cnt <= 3'd3; end
        end else if (m_cnt != 3'd0) begin
            m_cnt <= m_cnt - 3'd1;
        end else if (!m_hold) begin
            busy <= 1'b0; rx_data <= tx_data;
        end
    end

    for (genvar k = 0; k < 2; k++) begin : g_gap
        logic          l_busy, l_start, l_ready, l_rvalid;
        logic [31:0]   l_tx, l_rx, l_rdata;
        logic [AW-1:0] l_raddr, l_caddr;
        logic [1:0]    l_len, l_cnt;
        logic [CW-1:0] l_ccount, l_rcount;

        spi_cmd_queue #(.SLAVE_COUNT(8), .DEPTH(4), .GAP_CYCLES(k == 0 ? 0 : 3)) u_dut (
            .clk(clk), .rst(rst),
            .cmd_valid(g_cmd_valid[k]), .cmd_ready(l_ready), .cmd_data(32'h0000_0081),
            .cmd_addr(3'd1), .cmd_len(2'b00),
            .rsp_valid(l_rvalid), .rsp_ready(1'b1), .rsp_data(l_rdata), .rsp_addr(l_raddr),
            .start_trans(l_start), .busy(l_busy), .tx_data(l_tx),
            .chipADDRS(l_caddr), .transaction_length(l_len),
            .rx_data(l_rx), .cmd_count(l_ccount), .rsp_count(l_rcount)
        );

        // Fixed-length loopback master for the gap instances
        always @(posedge clk or negedge rst) begin
            if (!rst) begin
                l_busy <= 1'b0; l_cnt <= 2'd0; l_rx <= 32'h0;
            end else if (!l_busy) begin
                if (l_start) begin l_busy <= 1'b1; l_cnt <= 2'd2; end
            end else if (l_cnt != 2'd0) begin
                l_cnt <= l_cnt - 2'd1;
            end else begin
                l_busy <= 1'b0; l_rx <= l_tx;
            end
        end

        assign g_busy[k]  = l_busy;
        assign g_start[k] = l_start;
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_errors++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic push(input logic [31:0] d, input logic [2:0] a, input logic [1:0] l);
        cmd_valid = 1'b1; cmd_data = d; cmd_addr = a; cmd_len = l;
        tick();
        cmd_valid = 1'b0;
    endtask

    task automatic wait_busy(input logic lvl, input string tag);
        int n = 0;
        while (busy !== lvl && n < 300) begin tick(); n++; end
        check(tag, {31'd0, busy}, {31'd0, lvl});
    endtask

    task automatic wait_gbusy(input int k, input logic lvl, input string tag);
        int n = 0;
        while (g_busy[k] !== lvl && n < 300) begin tick(); n++; end
        check(tag, {31'd0, g_busy[k]}, {31'd0, lvl});
    endtask

    task automatic count_starts(input int cycles, output int n);
        n = 0;
        for (int i = 0; i < cycles; i++) begin
            tick();
            if (start_trans === 1'b1) n++;
        end
    endtask

    task automatic expect_rsp(input logic [31:0] d, input logic [2:0] a, input string tag);
        int n = 0;
        while (rsp_valid !== 1'b1 && n < 300) begin tick(); n++; end
        check({tag, "_valid"}, {31'd0, rsp_valid}, 32'd1);
        check({tag, "_data"}, rsp_data, d);
        check({tag, "_addr"}, {29'd0, rsp_addr}, {29'd0, a});
        rsp_ready = 1'b1;
        tick();
        rsp_ready = 1'b0;
    endtask

    initial begin
        int n;
        int gap_exp [2];
        gap_exp[0] = 2;
        gap_exp[1] = 5;
        rst = 1'b0; cmd_valid = 1'b0; cmd_data = 32'h0; cmd_addr = 3'd0; cmd_len = 2'b00;
        rsp_ready = 1'b0; m_hold = 1'b0; g_cmd_valid = 2'b00;

        // ---- reset values ----
        tick(); tick();
        check("rst_cmd_ready", {31'd0, cmd_ready}, 32'd1);
        check("rst_rsp_valid", {31'd0, rsp_valid}, 32'd0);
        check("rst_start", {31'd0, start_trans}, 32'd0);
        check("rst_cmd_count", {29'd0, cmd_count}, 32'd0);
        check("rst_rsp_count", {29'd0, rsp_count}, 32'd0);
        check("rst_tx_data", tx_data, 32'd0);
        check("rst_chip", {29'd0, chipADDRS}, 32'd0);
        check("rst_len", {30'd0, transaction_length}, 32'd0);
        rst = 1'b1;
        tick();

        // ---- single 8-bit command, loopback ----
        push(32'h0000_00A5, 3'd3, 2'b00);
        check("s1_count_pushed", {29'd0, cmd_count}, 32'd1);
        check("s1_start_early", {31'd0, start_trans}, 32'd0);
        tick();
        check("s1_start_high", {31'd0, start_trans}, 32'd1);
        check("s1_count_popped", {29'd0, cmd_count}, 32'd0);
        check("s1_tx", tx_data, 32'h0000_00A5);
        check("s1_chip", {29'd0, chipADDRS}, 32'd3);
        check("s1_len", {30'd0, transaction_length}, 32'd0);
        tick();
        check("s1_start_low", {31'd0, start_trans}, 32'd0);
        wait_busy(1'b1, "s1_busy_hi");
        wait_busy(1'b0, "s1_busy_lo");
        check("s1_rv_at_fall", {31'd0, rsp_valid}, 32'd0);
        tick();
        check("s1_rv_capture", {31'd0, rsp_valid}, 32'd0);
        tick();
        check("s1_rv_rise", {31'd0, rsp_valid}, 32'd1);
        check("s1_rsp_data", rsp_data, 32'h0000_00A5);
        check("s1_rsp_addr", {29'd0, rsp_addr}, 32'd3);
        rsp_ready = 1'b1; tick(); rsp_ready = 1'b0;
        check("s1_rsp_popped", {29'd0, rsp_count}, 32'd0);

        // ---- fill command FIFO behind a held transaction ----
        m_hold = 1'b1;
        push(32'h0000_00C3, 3'd6, 2'b00);
        wait_busy(1'b1, "s2_busy_hi");
        push(32'h0000_003C, 3'd0, 2'b00);
        check("s2_count1", {29'd0, cmd_count}, 32'd1);
        push(32'h0000_1234, 3'd2, 2'b01);
        check("s2_count2", {29'd0, cmd_count}, 32'd2);
        push(32'h00AB_CDEF, 3'd5, 2'b10);
        check("s2_ready3", {31'd0, cmd_ready}, 32'd1);
        push(32'hDEAD_BEEF, 3'd7, 2'b11);
        check("s2_count4", {29'd0, cmd_count}, 32'd4);
        check("s2_ready4", {31'd0, cmd_ready}, 32'd0);
        cmd_valid = 1'b1; cmd_data = 32'h0000_005A; cmd_addr = 3'd4; cmd_len = 2'b00;
        tick(); tick();
        check("s2_full_hold", {29'd0, cmd_count}, 32'd4);
        m_hold = 1'b0;
        n = 0;
        while (cmd_count == 3'd4 && n < 300) begin tick(); n++; end
        check("s2_pop_at_full", {29'd0, cmd_count}, 32'd3);
        check("s2_tx_q1", tx_data, 32'h0000_003C);
        check("s2_chip_q1", {29'd0, chipADDRS}, 32'd0);
        tick();
        check("s2_push_after", {29'd0, cmd_count}, 32'd4);
        cmd_valid = 1'b0;

        // ---- result FIFO backpressure ----
        n = 0;
        while (rsp_count != 3'd4 && n < 400) begin tick(); n++; end
        check("s3_rsp_full", {29'd0, rsp_count}, 32'd4);
        count_starts(30, n);
        check("s3_stall_starts", n, 32'd0);
        check("s3_cmd_left", {29'd0, cmd_count}, 32'd2);
        check("s3_head_data", rsp_data, 32'h0000_00C3);
        check("s3_head_addr", {29'd0, rsp_addr}, 32'd6);
        rsp_ready = 1'b1; tick(); rsp_ready = 1'b0;
        cmd_valid = 1'b1; cmd_data = 32'h0000_0777; cmd_addr = 3'd1; cmd_len = 2'b01;
        check("s3_rsp_after_pop", {29'd0, rsp_count}, 32'd3);
        tick();
        cmd_valid = 1'b0;
        check("s3_pushpop_count", {29'd0, cmd_count}, 32'd2);
        check("s3_relaunch", {31'd0, start_trans}, 32'd1);
        check("s3_tx_q4", tx_data, 32'hDEAD_BEEF);
        check("s3_len_q4", {30'd0, transaction_length}, 32'd3);
        count_starts(40, n);
        check("s3_one_launch", n, 32'd0);
        check("s3_rsp_full2", {29'd0, rsp_count}, 32'd4);
        check("s3_cmd_left2", {29'd0, cmd_count}, 32'd2);

        // ---- capture coinciding with a result pop ----
        check("s4_head_q1", rsp_data, 32'h0000_003C);
        rsp_ready = 1'b1; tick(); rsp_ready = 1'b0;
        wait_busy(1'b1, "s4_busy_hi");
        wait_busy(1'b0, "s4_busy_lo");
        tick();
        check("s4_count_before", {29'd0, rsp_count}, 32'd3);
        check("s4_head_q2", rsp_data, 32'h0000_1234);
        check("s4_head_q2_addr", {29'd0, rsp_addr}, 32'd2);
        rsp_ready = 1'b1; tick(); rsp_ready = 1'b0;
        check("s4_count_same", {29'd0, rsp_count}, 32'd3);
        expect_rsp(32'h00AB_CDEF, 3'd5, "s4_q3");
        expect_rsp(32'hDEAD_BEEF, 3'd7, "s4_q4");
        expect_rsp(32'h0000_005A, 3'd4, "s4_q5");
        expect_rsp(32'h0000_0777, 3'd1, "s4_q6");
        tick(); tick(); tick();
        check("s4_rsp_empty", {29'd0, rsp_count}, 32'd0);
        check("s4_cmd_empty", {29'd0, cmd_count}, 32'd0);

        // ---- reset during WAIT_DONE with two commands queued ----
        m_hold = 1'b1;
        push(32'h0000_1111, 3'd2, 2'b01);
        wait_busy(1'b1, "s5_busy_hi");
        tick(); tick();
        push(32'h0000_2222, 3'd3, 2'b00);
        push(32'h0000_3333, 3'd4, 2'b00);
        check("s5_queued", {29'd0, cmd_count}, 32'd2);
        rst = 1'b0;
        #1;
        check("s5_start", {31'd0, start_trans}, 32'd0);
        check("s5_cmd_count", {29'd0, cmd_count}, 32'd0);
        check("s5_cmd_ready", {31'd0, cmd_ready}, 32'd1);
        check("s5_rsp_valid", {31'd0, rsp_valid}, 32'd0);
        check("s5_tx", tx_data, 32'd0);
        check("s5_chip", {29'd0, chipADDRS}, 32'd0);
        check("s5_len", {30'd0, transaction_length}, 32'd0);
        m_hold = 1'b0;
        tick(); tick();
        rst = 1'b1;
        count_starts(20, n);
        check("s5_no_start", n, 32'd0);
        check("s5_cmd_after", {29'd0, cmd_count}, 32'd0);
        check("s5_rv_after", {31'd0, rsp_valid}, 32'd0);

        // ---- idle gap: sampling edge of busy-low to next start_trans ----
        for (int k = 0; k < 2; k++) begin
            g_cmd_valid[k] = 1'b1;
            tick(); tick();
            g_cmd_valid[k] = 1'b0;
            wait_gbusy(k, 1'b1, $sformatf("gap%0d_busy_hi", k));
            wait_gbusy(k, 1'b0, $sformatf("gap%0d_busy_lo", k));
            tick();
            n = 0;
            while (g_start[k] !== 1'b1 && n < 50) begin tick(); n++; end
            check($sformatf("gap_inst%0d_latency", k), n, gap_exp[k]);
            repeat (20) tick();
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end
endmodule
